// File: rtl/music_sequencer.sv
// Note-ROM sequencer feeding music_handler: fetches {note, duration} entries and holds each note
// for duration beats. Define MUSIC_SEQ_GAP_EN to insert a silent articulation gap after each note.
module music_sequencer #(
    parameter int ADDR_W         = 7,
    parameter int NOTE_W         = 8,
    parameter int DUR_W          = 4,
    parameter int TICKS_PER_BEAT = 8388608,
    parameter int GAP_CYCLES     = 1048576
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       fullnote,
    output logic                    note_on,
    output logic                    busy,
    output logic                    done
);

    localparam int BEAT_W = $clog2(TICKS_PER_BEAT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TICKS_PER_BEAT - 1);

`ifdef MUSIC_SEQ_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
`endif

    // A one-bit beat counter needs at least two ticks per beat; a gap needs at least one cycle.
    if (TICKS_PER_BEAT < 2 || GAP_CYCLES < 1) begin : g_bad_params
        $error("music_sequencer: TICKS_PER_BEAT must be >= 2 and GAP_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
`ifdef MUSIC_SEQ_GAP_EN
        S_GAP,
`endif
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                note_on_q, note_on_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
`ifdef MUSIC_SEQ_GAP_EN
    logic [GAP_W-1:0]    gap_q, gap_d;
`endif

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        note_d    = note_q;
        note_on_d = note_on_q;
        beat_d    = beat_q;
        dur_d     = dur_q;
`ifdef MUSIC_SEQ_GAP_EN
        gap_d     = gap_q;
`endif

        if (stop && (state_q != S_IDLE)) begin
            // Abort silences the output but leaves the address where it was.
            state_d   = S_IDLE;
            note_d    = '0;
            note_on_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end
                end

                S_FETCH: begin
                    state_d = S_LATCH;
                end

                S_LATCH: begin
                    if (rom_dur != '0) begin
                        note_d    = rom_note;
                        note_on_d = (rom_note != '0);
                        dur_d     = rom_dur;
                        beat_d    = '0;
                        state_d   = S_PLAY;
                    end else if (loop) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        note_d    = '0;
                        note_on_d = 1'b0;
                        state_d   = S_FINISH;
                    end
                end

                S_PLAY: begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        dur_d  = dur_q - DUR_W'(1);
                        if (dur_q == DUR_W'(1)) begin
                            addr_d = addr_q + ADDR_W'(1);
`ifdef MUSIC_SEQ_GAP_EN
                            note_d    = '0;
                            note_on_d = 1'b0;
                            gap_d     = '0;
                            state_d   = S_GAP;
`else
                            // The note keeps sounding through FETCH/LATCH of the next entry.
                            state_d = S_FETCH;
`endif
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end

`ifdef MUSIC_SEQ_GAP_EN
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_FETCH;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
`endif

                S_FINISH: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            note_q    <= '0;
            note_on_q <= 1'b0;
            beat_q    <= '0;
            dur_q     <= '0;
`ifdef MUSIC_SEQ_GAP_EN
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            note_q    <= note_d;
            note_on_q <= note_on_d;
            beat_q    <= beat_d;
            dur_q     <= dur_d;
`ifdef MUSIC_SEQ_GAP_EN
            gap_q     <= gap_d;
`endif
        end
    end

    assign rom_addr = addr_q;
    assign fullnote = note_q;
    assign note_on  = note_on_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FINISH);

endmodule
